// File: rtl/secret_driver.sv
// secret_driver: drives LFSR vectors into the secret block and checks its replies.
// Optional trace output: define SECRET_DRIVER_TRACE_EN.
module secret_driver #(
  parameter int unsigned NUM_CYCLES = 16,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_count,
  output logic          fail,
  output logic [31:0]   accum_in,
  input  logic [31:0]   accum_out,
  output logic          s1_in,
  input  logic          s1_out,
  output logic [1:0]    s2_in,
  input  logic [1:0]    s2_out,
  output logic [7:0]    s8_in,
  input  logic [7:0]    s8_out,
  output logic [32:0]   s33_in,
  input  logic [32:0]   s33_out,
  output logic [63:0]   s64_in,
  input  logic [63:0]   s64_out,
  output logic [64:0]   s65_in,
  input  logic [64:0]   s65_out,
  output logic [128:0]  s129_in,
  input  logic [128:0]  s129_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [15:0] LAST = 16'(NUM_CYCLES - 1);

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          drn_q, drn_d;
  logic          drive, clr, done_d;
  logic [31:0]   lfsr_q, lfsr_nxt;
  logic          drv_vld_q, exp_vld_q;
  logic [31:0]   exp_acc_q;
  logic          exp_s1_q;
  logic [1:0]    exp_s2_q;
  logic [7:0]    exp_s8_q;
  logic [32:0]   exp_s33_q;
  logic [63:0]   exp_s64_q;
  logic [64:0]   exp_s65_q;
  logic [128:0]  exp_s129_q;
  logic [7:0]    fld;
  logic          mism;
  logic [15:0]   err_d;
  logic          fail_d;

  assign busy = (state_q == RUN) || (state_q == DRAIN);

  assign lfsr_nxt = {lfsr_q[30:0],
                     lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = 1'b0;
    drive   = 1'b0;
    clr     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          drive   = 1'b1;
          clr     = 1'b1;
          cnt_d   = 16'd1;
          state_d = (NUM_CYCLES == 1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        drive = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        drn_d = ~drn_q;
        if (drn_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One bit per checked field; accumulator first.
  assign fld = {accum_out != exp_acc_q,
                s1_out    != exp_s1_q,
                s2_out    != exp_s2_q,
                s8_out    != exp_s8_q,
                s33_out   != exp_s33_q,
                s64_out   != exp_s64_q,
                s65_out   != exp_s65_q,
                s129_out  != exp_s129_q};

  assign mism = exp_vld_q && (fld != 8'h00);

  always_comb begin
    err_d  = err_count;
    fail_d = fail;
    if (clr) begin
      err_d  = '0;
      fail_d = 1'b0;
    end else if (mism) begin
      fail_d = 1'b1;
      if (err_count != 16'hFFFF) err_d = err_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drn_q      <= 1'b0;
      lfsr_q     <= SEED;
      done       <= 1'b0;
      err_count  <= '0;
      fail       <= 1'b0;
      drv_vld_q  <= 1'b0;
      exp_vld_q  <= 1'b0;
      accum_in   <= '0;
      s1_in      <= '0;
      s2_in      <= '0;
      s8_in      <= '0;
      s33_in     <= '0;
      s64_in     <= '0;
      s65_in     <= '0;
      s129_in    <= '0;
      exp_acc_q  <= '0;
      exp_s1_q   <= '0;
      exp_s2_q   <= '0;
      exp_s8_q   <= '0;
      exp_s33_q  <= '0;
      exp_s64_q  <= '0;
      exp_s65_q  <= '0;
      exp_s129_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drn_q     <= drn_d;
      done      <= done_d;
      err_count <= err_d;
      fail      <= fail_d;
      if (drive) lfsr_q <= lfsr_nxt;
      drv_vld_q <= drive;
      exp_vld_q <= drv_vld_q;
      accum_in  <= drive ? lfsr_q : '0;
      s1_in     <= drive ? lfsr_q[0] : 1'b0;
      s2_in     <= drive ? lfsr_q[1:0] : '0;
      s8_in     <= drive ? lfsr_q[7:0] : '0;
      s33_in    <= drive ? {lfsr_q[0], lfsr_q} : '0;
      s64_in    <= drive ? {~lfsr_q, lfsr_q} : '0;
      s65_in    <= drive ? {lfsr_q[0], ~lfsr_q, lfsr_q} : '0;
      s129_in   <= drive ? {lfsr_q[0], lfsr_q, ~lfsr_q,
                            lfsr_q, ~lfsr_q} : '0;
      // Idle cycles drive zeros, so the sum tracks the secret accumulator.
      exp_acc_q  <= exp_acc_q + accum_in;
      exp_s1_q   <= s1_in;
      exp_s2_q   <= s2_in;
      exp_s8_q   <= s8_in;
      exp_s33_q  <= s33_in;
      exp_s64_q  <= s64_in;
      exp_s65_q  <= s65_in;
      exp_s129_q <= s129_in;
    end
  end

`ifdef SECRET_DRIVER_TRACE_EN
  logic [15:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else if (clr) idx_q <= '0;
    else if (exp_vld_q) idx_q <= idx_q + 16'd1;
  end

  always @(posedge clk) begin
    if (rst_n && mism) begin
      $write("%0t secret_driver vec=%0d", $time, idx_q);
      if (fld[7]) $write(" acc exp=%h act=%h", exp_acc_q, accum_out);
      if (fld[6]) $write(" s1 exp=%h act=%h", exp_s1_q, s1_out);
      if (fld[5]) $write(" s2 exp=%h act=%h", exp_s2_q, s2_out);
      if (fld[4]) $write(" s8 exp=%h act=%h", exp_s8_q, s8_out);
      if (fld[3]) $write(" s33 exp=%h act=%h", exp_s33_q, s33_out);
      if (fld[2]) $write(" s64 exp=%h act=%h", exp_s64_q, s64_out);
      if (fld[1]) $write(" s65 exp=%h act=%h", exp_s65_q, s65_out);
      if (fld[0]) $write(" s129 exp=%h act=%h", exp_s129_q, s129_out);
      $write("\n");
    end
    if (rst_n && done_d)
      $write("secret_driver done errors=%0d\n", err_d);
  end
`else
  // Silent build: identical cycle behaviour, no simulation output.
`endif

endmodule

// File: tb/tb_secret_driver.sv
// tb_secret_driver: secret_driver against a behavioural secret block,
// checked every cycle by a run-relative model plus literal pins.
module tb_secret_driver;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start, start3, fault_acc, stuck, chk_en;
  logic busy, done, fail;
  logic [15:0] err_count;
  logic [31:0] accum_in, accum_out;
  logic s1_in, s1_out;
  logic [1:0] s2_in, s2_out;
  logic [7:0] s8_in, s8_out;
  logic [32:0] s33_in, s33_out;
  logic [63:0] s64_in, s64_out;
  logic [64:0] s65_in, s65_out;
  logic [128:0] s129_in, s129_out;

  logic busy3, done3, fail3;
  logic [15:0] err3;
  logic [31:0] acc3;
  logic s1_3;
  logic [1:0] s2_3;
  logic [7:0] s8_3;
  logic [32:0] s33_3;
  logic [63:0] s64_3;
  logic [64:0] s65_3;
  logic [128:0] s129_3;

  secret_driver #(.NUM_CYCLES(N), .SEED(32'h1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err_count(err_count), .fail(fail),
    .accum_in(accum_in), .accum_out(accum_out),
    .s1_in(s1_in), .s1_out(s1_out),
    .s2_in(s2_in), .s2_out(s2_out),
    .s8_in(s8_in), .s8_out(s8_out),
    .s33_in(s33_in), .s33_out(s33_out),
    .s64_in(s64_in), .s64_out(s64_out),
    .s65_in(s65_in), .s65_out(s65_out),
    .s129_in(s129_in), .s129_out(s129_out)
  );

  secret_driver #(.NUM_CYCLES(3), .SEED(32'h1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .busy(busy3), .done(done3), .err_count(err3), .fail(fail3),
    .accum_in(acc3), .accum_out(32'h0),
    .s1_in(s1_3), .s1_out(1'b0),
    .s2_in(s2_3), .s2_out(2'b0),
    .s8_in(s8_3), .s8_out(8'h0),
    .s33_in(s33_3), .s33_out(33'h0),
    .s64_in(s64_3), .s64_out(64'h0),
    .s65_in(s65_3), .s65_out(65'h0),
    .s129_in(s129_3), .s129_out(129'h0)
  );

  // Behavioural secret block with optional fault injection.
  logic [31:0] sec_acc;
  logic sec_s1;
  logic [1:0] sec_s2;
  logic [7:0] sec_s8;
  logic [32:0] sec_s33;
  logic [63:0] sec_s64;
  logic [64:0] sec_s65;
  logic [128:0] sec_s129;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_acc <= '0; sec_s1 <= '0; sec_s2 <= '0; sec_s8 <= '0;
      sec_s33 <= '0; sec_s64 <= '0; sec_s65 <= '0; sec_s129 <= '0;
    end else begin
      sec_acc <= sec_acc + accum_in;
      sec_s1 <= s1_in; sec_s2 <= s2_in; sec_s8 <= s8_in;
      sec_s33 <= s33_in; sec_s64 <= s64_in;
      sec_s65 <= s65_in; sec_s129 <= s129_in;
    end
  end

  assign accum_out = sec_acc + {31'd0, fault_acc & busy};
  assign s1_out = sec_s1;
  assign s2_out = sec_s2;
  assign s8_out = {sec_s8[7:1], sec_s8[0] & ~stuck};
  assign s33_out = sec_s33;
  assign s64_out = sec_s64;
  assign s65_out = sec_s65;
  assign s129_out = sec_s129;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction
  function automatic logic [32:0] v33(input logic [31:0] l);
    return {l[0], l};
  endfunction
  function automatic logic [63:0] v64(input logic [31:0] l);
    return {~l, l};
  endfunction
  function automatic logic [64:0] v65(input logic [31:0] l);
    return {l[0], ~l, l};
  endfunction
  function automatic logic [128:0] v129(input logic [31:0] l);
    return {l[0], l, ~l, l, ~l};
  endfunction

  // Model: rel = cycles since the start edge (-1 when idle).
  int rel = -1;
  int merr = 0;
  logic [31:0] ml = 32'h1;
  logic [31:0] macc = 32'h0;
  logic [31:0] mcur = 32'h0;
  logic mcur_v = 1'b0;
  logic [31:0] mv;
  logic [31:0] hv [N];
  logic [31:0] hacc [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel = -1; merr = 0; ml = 32'h1; macc = 32'h0;
      mcur = 32'h0; mcur_v = 1'b0;
    end else begin
      if (rel >= 1 && rel <= N) begin
        mv = hv[rel-1];
        if (s1_out !== mv[0] || s2_out !== mv[1:0] ||
            s8_out !== mv[7:0] || s33_out !== v33(mv) ||
            s64_out !== v64(mv) || s65_out !== v65(mv) ||
            s129_out !== v129(mv) || accum_out !== hacc[rel-1])
          if (merr < 65535) merr = merr + 1;
      end
      if (rel < 0 || rel == N + 1) begin
        if (start) begin
          rel = 0;
          merr = 0;
        end else rel = -1;
      end else rel = rel + 1;
      if (rel >= 0 && rel < N) begin
        hv[rel] = ml;
        macc = macc + ml;
        hacc[rel] = macc;
        mcur = ml;
        mcur_v = 1'b1;
        ml = nxt(ml);
      end else mcur_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 256'(busy), 256'(rel >= 0 && rel <= N));
      chk("done", 256'(done), 256'(rel == N + 1));
      chk("err_count", 256'(err_count), 256'(merr));
      chk("fail", 256'(fail), 256'(merr != 0));
      chk("accum_in", 256'(accum_in), 256'(mcur_v ? mcur : 32'h0));
      chk("s1_in", 256'(s1_in), 256'(mcur_v & mcur[0]));
      chk("s2_in", 256'(s2_in), 256'(mcur_v ? mcur[1:0] : 2'h0));
      chk("s8_in", 256'(s8_in), 256'(mcur_v ? mcur[7:0] : 8'h0));
      chk("s33_in", 256'(s33_in), 256'(mcur_v ? v33(mcur) : 33'h0));
      chk("s64_in", 256'(s64_in), 256'(mcur_v ? v64(mcur) : 64'h0));
      chk("s65_in", 256'(s65_in), 256'(mcur_v ? v65(mcur) : 65'h0));
      chk("s129_in", 256'(s129_in),
          256'(mcur_v ? v129(mcur) : 129'h0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk({nm, "_done_seen"}, 256'(seen), 256'(1'b1));
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [128:0] k129;
  logic seen_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    fault_acc = 1'b0; stuck = 1'b0; chk_en = 1'b0;
    k129 = {1'b1, 32'h0000_0001, 32'hFFFF_FFFE,
            32'h0000_0001, 32'hFFFF_FFFE};

    @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err_count), 256'(0));
    chk("rst_fail", 256'(fail), 256'(0));
    chk("rst_s129", 256'(s129_in), 256'(0));
    chk("rst_acc", 256'(accum_in), 256'(0));
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Run 1: start edge at cycle 10, correct secret block.
    while (cyc < 9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("run1_v0_s8", 256'(s8_in), 256'(8'h01));
    chk("run1_v0_s129", 256'(s129_in), 256'(k129));
    repeat (3) @(negedge clk);
    chk("run1_v3_acc", 256'(accum_in), 256'(32'hD));
    @(negedge clk);
    chk("run1_busy14", 256'(busy), 256'(1));
    wait_done("run1");
    chk("run1_done_cyc", 256'(cyc), 256'(15));
    chk("run1_err", 256'(err_count), 256'(0));
    chk("run1_fail", 256'(fail), 256'(0));

    // Run 2: accumulator reply off by one during the run.
    tick();
    fault_acc = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("run2");
    chk("run2_err", 256'(err_count), 256'(4));
    chk("run2_fail", 256'(fail), 256'(1));
    fault_acc = 1'b0;

    // Run 3: s8_out bit 0 stuck low; vectors 1B6,36D,6DB,DB6.
    tick();
    stuck = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("run3");
    chk("run3_err", 256'(err_count), 256'(2));
    stuck = 1'b0;

    // Runs 4 and 5 back to back.
    pulse_start();
    @(negedge clk);
    chk("run4_v0_acc", 256'(accum_in), 256'(32'h1B6D));
    wait_done("run4");
    chk("run4_err", 256'(err_count), 256'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("run5_v0_acc", 256'(accum_in), 256'(32'h1B6DB));
    wait_done("run5");
    chk("run5_err", 256'(err_count), 256'(0));
    chk("run5_fail", 256'(fail), 256'(0));

    // Run 6: reset in the second RUN cycle.
    pulse_start();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s129", 256'(s129_in), 256'(0));
    chk("mid_rst_acc", 256'(accum_in), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("mid_rst_no_done", 256'(seen_done), 256'(0));

    // Run 7: LFSR restarts from SEED after reset.
    pulse_start();
    @(negedge clk);
    chk("run7_v0_acc", 256'(accum_in), 256'(32'h1));
    wait_done("run7");
    chk("run7_err", 256'(err_count), 256'(0));

    // start held high on the NUM_CYCLES=3 instance.
    tick();
    start3 = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("held_busy3", 256'(busy3), 256'((i % 5) != 4));
      chk("held_done3", 256'(done3), 256'((i % 5) == 4));
    end
    start3 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
